// File: rtl/ifetch_port_arbiter.sv
// Shares the single I-Cache fetch port between the way0/way1 IFUs: round-robin grant,
// one outstanding fetch, and squash of the in-flight fetch on a pipeline redirect.
//   state | meaning
//   IDLE  | no fetch outstanding, arbitrating between ways
//   WAIT  | fetch outstanding, response goes to the owner
//   DROP  | fetch squashed by a jump, response is discarded
module ifetch_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              way0_request_i,
    input  logic [ADDR_W-1:0] way0_instAddr_i,
    output logic              way0_dataOk_o,
    output logic [INST_W-1:0] way0_inst_o,
    input  logic              way1_request_i,
    input  logic [ADDR_W-1:0] way1_instAddr_i,
    output logic              way1_dataOk_o,
    output logic [INST_W-1:0] way1_inst_o,
    input  logic              jumpFlag_i,
    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_instAddr_o,
    input  logic              mem_dataOk_i,
    input  logic [INST_W-1:0] mem_inst_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_request_q, mem_request_d;
    logic [ADDR_W-1:0] mem_inst_addr_q, mem_inst_addr_d;
    logic              way0_data_ok_q, way0_data_ok_d;
    logic              way1_data_ok_q, way1_data_ok_d;
    logic [INST_W-1:0] way0_inst_q, way0_inst_d;
    logic [INST_W-1:0] way1_inst_q, way1_inst_d;
    logic              grant_valid;
    logic              grant_way;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        mem_request_d   = mem_request_q;
        mem_inst_addr_d = mem_inst_addr_q;
        way0_data_ok_d  = 1'b0;
        way1_data_ok_d  = 1'b0;
        way0_inst_d     = way0_inst_q;
        way1_inst_d     = way1_inst_q;

        // On a tie the way that did not win last time goes next.
        grant_valid = (way0_request_i | way1_request_i) & ~jumpFlag_i;
        grant_way   = (way0_request_i & way1_request_i) ? ~last_grant_q : way1_request_i;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d         = grant_way;
                    last_grant_d    = grant_way;
                    mem_inst_addr_d = grant_way ? way1_instAddr_i : way0_instAddr_i;
                    mem_request_d   = 1'b1;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (mem_dataOk_i) begin
                    mem_request_d = 1'b0;
                    state_d       = IDLE;
                    if (!jumpFlag_i) begin
                        if (owner_q) begin
                            way1_data_ok_d = 1'b1;
                            way1_inst_d    = mem_inst_i;
                        end else begin
                            way0_data_ok_d = 1'b1;
                            way0_inst_d    = mem_inst_i;
                        end
                    end
                end else if (jumpFlag_i) begin
                    // The cache transaction cannot be cancelled, so keep requesting and discard later.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_dataOk_i) begin
                    mem_request_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                mem_request_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            mem_request_q   <= 1'b0;
            mem_inst_addr_q <= '0;
            way0_data_ok_q  <= 1'b0;
            way1_data_ok_q  <= 1'b0;
            way0_inst_q     <= '0;
            way1_inst_q     <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            mem_request_q   <= mem_request_d;
            mem_inst_addr_q <= mem_inst_addr_d;
            way0_data_ok_q  <= way0_data_ok_d;
            way1_data_ok_q  <= way1_data_ok_d;
            way0_inst_q     <= way0_inst_d;
            way1_inst_q     <= way1_inst_d;
        end
    end

    assign mem_request_o  = mem_request_q;
    assign mem_instAddr_o = mem_inst_addr_q;
    assign way0_dataOk_o  = way0_data_ok_q;
    assign way1_dataOk_o  = way1_data_ok_q;
    assign way0_inst_o    = way0_inst_q;
    assign way1_inst_o    = way1_inst_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ifetch_port_arbiter.sv
// Directed self-checking bench for ifetch_port_arbiter: grants, round-robin, squash and reset.
module tb_ifetch_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk;
    logic              reset_n;
    logic              way0_request_i;
    logic [ADDR_W-1:0] way0_instAddr_i;
    logic              way0_dataOk_o;
    logic [INST_W-1:0] way0_inst_o;
    logic              way1_request_i;
    logic [ADDR_W-1:0] way1_instAddr_i;
    logic              way1_dataOk_o;
    logic [INST_W-1:0] way1_inst_o;
    logic              jumpFlag_i;
    logic              mem_request_o;
    logic [ADDR_W-1:0] mem_instAddr_o;
    logic              mem_dataOk_i;
    logic [INST_W-1:0] mem_inst_i;
    logic              busy_o;

    int tests_run;
    int tests_failed;

    ifetch_port_arbiter #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .way0_request_i  (way0_request_i),
        .way0_instAddr_i (way0_instAddr_i),
        .way0_dataOk_o   (way0_dataOk_o),
        .way0_inst_o     (way0_inst_o),
        .way1_request_i  (way1_request_i),
        .way1_instAddr_i (way1_instAddr_i),
        .way1_dataOk_o   (way1_dataOk_o),
        .way1_inst_o     (way1_inst_o),
        .jumpFlag_i      (jumpFlag_i),
        .mem_request_o   (mem_request_o),
        .mem_instAddr_o  (mem_instAddr_o),
        .mem_dataOk_i    (mem_dataOk_i),
        .mem_inst_i      (mem_inst_i),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs set afterwards apply at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        way0_request_i  = 1'b0;
        way0_instAddr_i = '0;
        way1_request_i  = 1'b0;
        way1_instAddr_i = '0;
        jumpFlag_i      = 1'b0;
        mem_dataOk_i    = 1'b0;
        mem_inst_i      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic        exp_way;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;

        tests_run    = 0;
        tests_failed = 0;
        do_reset();

        check_eq("rst_mem_req", mem_request_o, 0);
        check_eq("rst_addr", mem_instAddr_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ok0", way0_dataOk_o, 0);
        check_eq("rst_ok1", way1_dataOk_o, 0);
        check_eq("rst_inst0", way0_inst_o, 0);

        // Single way0 fetch, cache answers 3 cycles after the request rises.
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h8000_0000;
        tick();
        check_eq("t1_req", mem_request_o, 1);
        check_eq("t1_addr", mem_instAddr_o, 32'h8000_0000);
        check_eq("t1_busy", busy_o, 1);
        way0_instAddr_i = 32'h1234_5678;
        tick();
        check_eq("t1_addr_hold", mem_instAddr_o, 32'h8000_0000);
        tick();
        check_eq("t1_req_hold", mem_request_o, 1);
        check_eq("t1_no_early_ok", way0_dataOk_o, 0);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0013;
        tick();
        mem_dataOk_i   = 1'b0;
        way0_request_i = 1'b0;
        check_eq("t1_ok0", way0_dataOk_o, 1);
        check_eq("t1_inst0", way0_inst_o, 32'h13);
        check_eq("t1_ok1", way1_dataOk_o, 0);
        check_eq("t1_req_drop", mem_request_o, 0);
        check_eq("t1_idle", busy_o, 0);
        tick();
        check_eq("t1_pulse_one", way0_dataOk_o, 0);
        check_eq("t1_inst_hold", way0_inst_o, 32'h13);

        // Both ways requesting continuously, cache latency 1: strict alternation.
        do_reset();
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h100;
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_way  = k[0];
            exp_addr = exp_way ? 32'h200 : 32'h100;
            exp_inst = 32'hA000 + k;
            tick();
            check_eq($sformatf("t2_req_%0d", k), mem_request_o, 1);
            check_eq($sformatf("t2_addr_%0d", k), mem_instAddr_o, exp_addr);
            mem_dataOk_i = 1'b1;
            mem_inst_i   = exp_inst;
            tick();
            mem_dataOk_i = 1'b0;
            check_eq($sformatf("t2_ok0_%0d", k), way0_dataOk_o, !exp_way);
            check_eq($sformatf("t2_ok1_%0d", k), way1_dataOk_o, exp_way);
            check_eq($sformatf("t2_inst_%0d", k), exp_way ? way1_inst_o : way0_inst_o, exp_inst);
        end
        clear_inputs();
        tick();

        // way1 granted, jump one cycle into WAIT, cache answers two cycles later.
        do_reset();
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h300;
        tick();
        check_eq("t3_req", mem_request_o, 1);
        check_eq("t3_addr", mem_instAddr_o, 32'h300);
        jumpFlag_i = 1'b1;
        tick();
        jumpFlag_i = 1'b0;
        check_eq("t3_drop_busy", busy_o, 1);
        check_eq("t3_drop_req", mem_request_o, 1);
        tick();
        check_eq("t3_drop_req2", mem_request_o, 1);
        check_eq("t3_no_ok_early", way1_dataOk_o, 0);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hDEAD_BEEF;
        tick();
        mem_dataOk_i = 1'b0;
        check_eq("t3_no_ok1", way1_dataOk_o, 0);
        check_eq("t3_no_ok0", way0_dataOk_o, 0);
        check_eq("t3_inst1_kept", way1_inst_o, 0);
        check_eq("t3_idle", busy_o, 0);
        check_eq("t3_req_drop", mem_request_o, 0);
        tick();
        check_eq("t3_regrant", mem_request_o, 1);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0301;
        tick();
        mem_dataOk_i   = 1'b0;
        way1_request_i = 1'b0;
        check_eq("t3_ok1_after", way1_dataOk_o, 1);
        check_eq("t3_inst1_after", way1_inst_o, 32'h301);

        // Jump coincident with the cache response in WAIT.
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h400;
        tick();
        check_eq("t4_req", mem_request_o, 1);
        way0_request_i = 1'b0;
        mem_dataOk_i   = 1'b1;
        mem_inst_i     = 32'h0000_0444;
        jumpFlag_i     = 1'b1;
        tick();
        mem_dataOk_i = 1'b0;
        jumpFlag_i   = 1'b0;
        check_eq("t4_no_ok0", way0_dataOk_o, 0);
        check_eq("t4_no_ok1", way1_dataOk_o, 0);
        check_eq("t4_idle", busy_o, 0);
        check_eq("t4_req_drop", mem_request_o, 0);

        // Jump held in IDLE blocks the grant until it falls.
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h500;
        jumpFlag_i      = 1'b1;
        tick();
        check_eq("t5_blocked", mem_request_o, 0);
        check_eq("t5_blocked_busy", busy_o, 0);
        tick();
        check_eq("t5_blocked2", mem_request_o, 0);
        jumpFlag_i = 1'b0;
        tick();
        check_eq("t5_grant", mem_request_o, 1);
        check_eq("t5_addr", mem_instAddr_o, 32'h500);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0555;
        tick();
        mem_dataOk_i   = 1'b0;
        way0_request_i = 1'b0;
        check_eq("t5_ok0", way0_dataOk_o, 1);
        check_eq("t5_inst0", way0_inst_o, 32'h555);
        tick();

        // Reset during WAIT, late cache response, then first tie goes to way0.
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h600;
        tick();
        check_eq("t6_req", mem_request_o, 1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_req", mem_request_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_addr", mem_instAddr_o, 0);
        check_eq("t6_rst_inst0", way0_inst_o, 0);
        check_eq("t6_rst_inst1", way1_inst_o, 0);
        clear_inputs();
        tick();
        reset_n      = 1'b1;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0666;
        tick();
        mem_dataOk_i = 1'b0;
        check_eq("t6_late_ok0", way0_dataOk_o, 0);
        check_eq("t6_late_ok1", way1_dataOk_o, 0);
        check_eq("t6_late_busy", busy_o, 0);
        way0_request_i  = 1'b1;
        way0_instAddr_i = 32'h700;
        way1_request_i  = 1'b1;
        way1_instAddr_i = 32'h800;
        tick();
        check_eq("t6_tie_addr", mem_instAddr_o, 32'h700);
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0000_0777;
        tick();
        mem_dataOk_i = 1'b0;
        clear_inputs();
        check_eq("t6_tie_ok0", way0_dataOk_o, 1);
        check_eq("t6_tie_ok1", way1_dataOk_o, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
